// File: rtl/ifu.sv
// Instruction fetch unit: accepts one PC, performs a single memory read and
// hands the instruction to decode. Optional IFU_ACCESS_FAULT_EN reports rresp errors.
module ifu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_pc,
  output logic [WIDTH-1:0] araddr,
  output logic             arvalid,
  input  logic             arready,
  input  logic [31:0]      rdata,
  input  logic [1:0]       rresp,
  input  logic             rvalid,
  output logic             rready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_inst,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    AR   = 2'd1,
    R    = 2'd2,
    OUT  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic             fault_q, fault_d;
  logic             in_ready_q, arvalid_q, rready_q, out_valid_q;

  function automatic logic resp_fault(input logic [1:0] resp);
`ifdef IFU_ACCESS_FAULT_EN
    return (resp != 2'b00);
`else
    return (|resp) & 1'b0;
`endif
  endfunction

  // Next-state and datapath capture
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    fault_d = fault_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          state_d = AR;
          pc_d    = in_pc;
        end else begin
          state_d = IDLE;
        end
      end
      AR: begin
        if (arready) begin
          state_d = R;
        end else begin
          state_d = AR;
        end
      end
      R: begin
        if (rvalid) begin
          state_d = OUT;
          inst_d  = rdata;
          fault_d = resp_fault(rresp);
        end else begin
          state_d = R;
        end
      end
      OUT: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and registered handshake flags (flags decode the next state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= {WIDTH{1'b0}};
      inst_q      <= 32'h0000_0000;
      fault_q     <= 1'b0;
      in_ready_q  <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      fault_q     <= fault_d;
      in_ready_q  <= (state_d == IDLE);
      arvalid_q   <= (state_d == AR);
      rready_q    <= (state_d == R);
      out_valid_q <= (state_d == OUT);
    end
  end

  assign in_ready  = in_ready_q;
  assign arvalid   = arvalid_q;
  assign rready    = rready_q;
  assign out_valid = out_valid_q;
  assign araddr    = pc_q;
  assign out_pc    = pc_q;
  assign out_inst  = inst_q;
  assign out_fault = fault_q & out_valid_q;

endmodule

// File: tb/tb_ifu.sv
// Directed self-checking bench for ifu.
module tb_ifu;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_fault;

  int total = 0;
  int bad   = 0;
  logic [31:0] hs_pc[$];
  logic [31:0] hs_inst[$];
  logic        fault_exp;

  ifu #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_fault(out_fault)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst && out_valid && out_ready) begin
      hs_pc.push_back(out_pc);
      hs_inst.push_back(out_inst);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
`ifdef IFU_ACCESS_FAULT_EN
    fault_exp = 1'b1;
`else
    fault_exp = 1'b0;
`endif
    rst = 1'b1; in_valid = 1'b0; in_pc = 32'h0; arready = 1'b0;
    rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0; out_ready = 1'b0;
    step(); step();
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_arvalid", {31'd0, arvalid}, 32'd0);
    check("rst_rready", {31'd0, rready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_fault", {31'd0, out_fault}, 32'd0);
    check("rst_araddr", araddr, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    rst = 1'b0;
    step();
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    // Minimum-latency fetch
    arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0413; out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h8000_0000;
    step();
    in_valid = 1'b0;
    check("lat_c1_arvalid", {31'd0, arvalid}, 32'd1);
    check("lat_c1_araddr", araddr, 32'h8000_0000);
    check("lat_c1_in_ready", {31'd0, in_ready}, 32'd0);
    step();
    check("lat_c2_rready", {31'd0, rready}, 32'd1);
    check("lat_c2_out_valid", {31'd0, out_valid}, 32'd0);
    step();
    check("lat_c3_out_valid", {31'd0, out_valid}, 32'd1);
    check("lat_c3_out_inst", out_inst, 32'h0000_0413);
    check("lat_c3_out_pc", out_pc, 32'h8000_0000);
    check("lat_c3_out_fault", {31'd0, out_fault}, 32'd0);
    step();
    check("lat_back_idle", {31'd0, in_ready}, 32'd1);
    check("lat_out_valid_low", {31'd0, out_valid}, 32'd0);

    // Address phase stalled by arready
    arready = 1'b0; rvalid = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h8000_0004;
    step();
    in_valid = 1'b0; in_pc = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      check("ar_stall_arvalid", {31'd0, arvalid}, 32'd1);
      check("ar_stall_araddr", araddr, 32'h8000_0004);
      check("ar_stall_rready", {31'd0, rready}, 32'd0);
      if (i == 3) arready = 1'b1;
      step();
    end
    arready = 1'b0;
    check("ar_to_r_rready", {31'd0, rready}, 32'd1);
    check("ar_to_r_arvalid", {31'd0, arvalid}, 32'd0);

    // Output held under backpressure, in_valid pulse ignored
    rvalid = 1'b1; rdata = 32'h0010_0093;
    step();
    rvalid = 1'b0; rdata = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      check("bp_out_valid", {31'd0, out_valid}, 32'd1);
      check("bp_out_inst", out_inst, 32'h0010_0093);
      check("bp_out_pc", out_pc, 32'h8000_0004);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = (i == 2);
      in_pc = 32'h0000_1234;
      step();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    check("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    check("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    check("bp_pulse_no_fetch", {31'd0, arvalid}, 32'd0);

    // Error response
    arready = 1'b1; rvalid = 1'b1; rresp = 2'b10; rdata = 32'h0000_0013; out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h8000_0100;
    step();
    in_valid = 1'b0;
    step(); step();
    rvalid = 1'b0; rresp = 2'b00;
    check("fault_out_valid", {31'd0, out_valid}, 32'd1);
    check("fault_flag", {31'd0, out_fault}, {31'd0, fault_exp});
    step();
    check("fault_held", {31'd0, out_fault}, {31'd0, fault_exp});
    out_ready = 1'b1;
    step();
    check("fault_cleared", {31'd0, out_fault}, 32'd0);

    // Reset while waiting for read data
    in_valid = 1'b1; in_pc = 32'h8000_0200; rdata = 32'hCAFE_0001;
    step();
    in_valid = 1'b0;
    step();
    check("mid_rst_in_r", {31'd0, rready}, 32'd1);
    rst = 1'b1;
    step();
    check("mid_rst_rready", {31'd0, rready}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("mid_rst_araddr", araddr, 32'd0);
    rst = 1'b0; rvalid = 1'b1;
    step();
    rvalid = 1'b0;
    check("post_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_out_inst", out_inst, 32'd0);
    step();
    check("post_rst_still_idle", {31'd0, out_valid}, 32'd0);

    // Eight back-to-back fetches
    begin
      int base_n;
      base_n = hs_pc.size();
      arready = 1'b1; rvalid = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
        in_pc = 32'h8000_0000 + 32'(4 * k);
        rdata = 32'hA5A5_0000 + 32'(k);
        step();
        check("b2b_araddr", araddr, 32'h8000_0000 + 32'(4 * k));
        step(); step();
        check("b2b_out_pc", out_pc, 32'h8000_0000 + 32'(4 * k));
        check("b2b_out_inst", out_inst, 32'hA5A5_0000 + 32'(k));
        step();
        check("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      end
      in_valid = 1'b0; rvalid = 1'b0;
      step();
      check("b2b_hs_count", 32'(hs_pc.size() - base_n), 32'd8);
      for (int k = 0; k < 8; k++) begin
        if (base_n + k < hs_pc.size()) begin
          check("b2b_hs_pc", hs_pc[base_n + k], 32'h8000_0000 + 32'(4 * k));
          check("b2b_hs_inst", hs_inst[base_n + k], 32'hA5A5_0000 + 32'(k));
        end else begin
          check("b2b_hs_missing", 32'(base_n + k), 32'(hs_pc.size()));
        end
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ifu.md
IFU -- requirements
Module: ifu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, address/data width.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream PC offers a fetch address.
REQ-005 SHALL have port in_ready  output  1  IFU accepts a new fetch address.
REQ-006 SHALL have port in_pc  input  WIDTH  address of instruction to fetch.
REQ-007 SHALL have port araddr  output  WIDTH  memory read address.
REQ-008 SHALL have port arvalid  output  1  read address valid.
REQ-009 SHALL have port arready  input  1  memory accepts read address.
REQ-010 SHALL have port rdata  input  32  read data.
REQ-011 SHALL have port rresp  input  2  read response; 2'b00 = OKAY.
REQ-012 SHALL have port rvalid  input  1  read data valid.
REQ-013 SHALL have port rready  output  1  IFU accepts read data.
REQ-014 SHALL have port out_valid  output  1  fetched instruction valid to decode.
REQ-015 SHALL have port out_ready  input  1  decode accepts instruction.
REQ-016 SHALL have port out_inst  output  32  fetched instruction.
REQ-017 SHALL have port out_pc  output  WIDTH  address of out_inst.
REQ-018 SHALL have port out_fault  output  1  access fault flag for out_inst (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, AR, R, OUT; one state active at a time.
REQ-020 SHALL in IDLE drive in_ready=1; on in_valid latch in_pc into pc_q and move to AR next cycle.
REQ-021 SHALL drive in_ready=0 in AR, R, OUT; in_valid there is ignored, in_pc not sampled.
REQ-022 SHALL in AR drive arvalid=1, araddr=pc_q; araddr stable while arvalid=1; on arready move to R.
REQ-023 SHALL in R drive rready=1; on rvalid latch rdata into inst_q, latch fault, move to OUT.
REQ-024 SHALL drive arvalid=0 outside AR and rready=0 outside R; rvalid outside R is not consumed.
REQ-025 SHALL in OUT drive out_valid=1, out_inst=inst_q, out_pc=pc_q, holding all stable until out_ready=1; then IDLE next cycle.
REQ-026 SHALL give minimum latency of 3 cycles from in_valid&in_ready to out_valid (arready and rvalid both 1 on first opportunity).
REQ-027 SHALL accept a new fetch only after the previous instruction is consumed; no more than one outstanding read.
REQ-028 SHALL fetch misaligned in_pc (in_pc[1:0]!=0) unchanged; alignment checking is outside this block.
REQ-029 SHALL keep in_ready, out_valid, arvalid, rready registered state decodes, not combinational from inputs.

Reset
REQ-030 SHALL on rst=1 at a clock edge enter IDLE and clear pc_q, inst_q, fault, regardless of state.
REQ-031 SHALL while rst=1 drive in_ready=0, arvalid=0, rready=0, out_valid=0, out_fault=0, araddr=0, out_inst=0, out_pc=0.
REQ-032 SHALL on reset mid-transaction abandon it; a late rvalid is not consumed and produces no out_valid.

Configuration
REQ-033 SHALL with macro IFU_ACCESS_FAULT_EN defined set out_fault=1 when the latched rresp!=2'b00, held with out_valid.
REQ-034 SHALL with IFU_ACCESS_FAULT_EN undefined ignore rresp and tie out_fault=0.

Verification
REQ-035 SHALL cover: in_pc=0x80000000, arready=1, rvalid=1, rdata=0x00000413, out_ready=1 -> out_valid 3 cycles after accept, out_inst=0x00000413, out_pc=0x80000000.
REQ-036 SHALL cover: arready delayed 4 cycles -> arvalid=1, araddr=0x80000004 stable all 4 cycles, then R.
REQ-037 SHALL cover: out_ready=0 for 5 cycles -> out_valid, out_inst, out_pc stable; in_ready=0; in_valid pulse ignored.
REQ-038 SHALL cover: rst=1 in R with rvalid arriving next cycle -> IDLE, out_valid=0, in_ready=1 after rst drops.
REQ-039 SHALL cover: rresp=2'b10 with IFU_ACCESS_FAULT_EN defined -> out_fault=1; undefined -> out_fault=0.
REQ-040 SHALL cover: 8 back-to-back fetches 0x80000000..0x8000001C -> 8 out handshakes in order, no duplicate or lost instruction.
